// File: rtl/riscv_loader_pkg.sv
// Shared types and helpers for the UART memory loaders.
// The CKSUM state is defined here but is only entered when RISCV_IMEM_LOADER_CKSUM_EN is set.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CKSUM,
    DONE,
    ERR
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // A length equal to the full RAM size is legal; anything larger is not.
  function automatic logic len_too_big(input logic [15:0] len, input int addr_w);
    return 32'(len) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/riscv_loader_timeout.sv
// Inter-byte idle watchdog. It pulses expire_o for one cycle after TIMEOUT_CYC
// consecutive enabled cycles without a clear.
module riscv_loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q;

  assign expire_o = en && !clr && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en || clr || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

endmodule

// File: rtl/riscv_imem_loader.sv
// UART programmer for the instruction RAM: frames length + little-endian words and
// drives the upg_* write port. Optional trailer checksum: RISCV_IMEM_LOADER_CKSUM_EN.
module riscv_imem_loader
  import riscv_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              err_o
);

  state_e            state_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_buf_q;
  logic              fin_q;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic load_go;
  logic last_word;
  logic to_en;
  logic to_expire;

  assign load_go   = load_req && (state_q inside {IDLE, DONE, ERR});
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(len_q);
  assign to_en     = (state_q inside {LEN0, LEN1, DATA, CKSUM}) && !fin_q;

  riscv_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .en       (to_en),
    .clr      (rx_valid),
    .expire_o (to_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      fin_q      <= 1'b0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b1;
      cpu_hold_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      upg_wen_o <= 1'b0;
      if (load_go) begin
        state_q    <= LEN0;
        word_idx_q <= '0;
        byte_idx_q <= '0;
        fin_q      <= 1'b0;
        upg_done_o <= 1'b0;
        cpu_hold_o <= 1'b1;
        busy_o     <= 1'b1;
        err_o      <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
        sum_q      <= '0;
`endif
      end else if (to_expire) begin
        state_q <= ERR;
        busy_o  <= 1'b0;
        err_o   <= 1'b1;
      end else begin
        case (state_q)
          LEN0: if (rx_valid) begin
            len_q[7:0] <= rx_data;
            state_q    <= LEN1;
          end
          LEN1: if (rx_valid) begin
            len_q[15:8] <= rx_data;
            if ({rx_data, len_q[7:0]} == 16'd0) begin
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
              state_q <= CKSUM;
`else
              state_q    <= DONE;
              upg_done_o <= 1'b1;
              cpu_hold_o <= 1'b0;
              busy_o     <= 1'b0;
`endif
            end else if (len_too_big({rx_data, len_q[7:0]}, ADDR_W)) begin
              state_q <= ERR;
              busy_o  <= 1'b0;
              err_o   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            // Release fetch one cycle after the final strobe so the last write
            // lands while the CPU is still held.
            if (fin_q) begin
              fin_q      <= 1'b0;
              state_q    <= DONE;
              upg_done_o <= 1'b1;
              cpu_hold_o <= 1'b0;
              busy_o     <= 1'b0;
            end else if (rx_valid) begin
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
              sum_q <= sum_q + rx_data;
`endif
              byte_idx_q <= byte_idx_q + 2'd1;
              case (byte_idx_q)
                2'd0: word_buf_q[7:0]   <= rx_data;
                2'd1: word_buf_q[15:8]  <= rx_data;
                2'd2: word_buf_q[23:16] <= rx_data;
                default: begin
                  upg_wen_o  <= 1'b1;
                  upg_adr_o  <= word_idx_q;
                  upg_dat_o  <= {rx_data, word_buf_q};
                  word_idx_q <= word_idx_q + ADDR_W'(1);
                  if (last_word) begin
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
                    state_q <= CKSUM;
`else
                    fin_q <= 1'b1;
`endif
                  end
                end
              endcase
            end
          end
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
          CKSUM: if (rx_valid) begin
            if (rx_data == sum_q) begin
              state_q    <= DONE;
              upg_done_o <= 1'b1;
              cpu_hold_o <= 1'b0;
              busy_o     <= 1'b0;
            end else begin
              state_q <= ERR;
              busy_o  <= 1'b0;
              err_o   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Scoreboard bench for riscv_imem_loader: a frame-level model queues expected RAM
// writes and the final outcome; a negedge monitor pops and compares every write strobe.
module tb_riscv_imem_loader;

  localparam int ADDR_W      = 14;
  localparam int TIMEOUT_CYC = 50;
  localparam int TO_W        = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0]       upg_dat_o;
  logic              upg_done_o;
  logic              cpu_hold_o;
  logic              busy_o;
  logic              err_o;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  riscv_imem_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst && upg_wen_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got adr=%0h dat=%0h required no write", upg_adr_o, upg_dat_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_adr", 64'(upg_adr_o), 64'(e.adr));
        check("wr_dat", 64'(upg_dat_o), 64'(e.dat));
        check("wr_hold_done", {cpu_hold_o, upg_done_o}, 2'b10);
      end
    end
  end

  // Reference model: outcome 0 = image loaded, 1 = error. Bytes past the frame are ignored.
  task automatic model(input logic [7:0] f[$], output int outcome, output int len);
    int  n;
    int  need;
    wr_t w;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    logic [7:0] sum;
    sum = 8'h00;
`endif
    n = f.size();
    outcome = 1;
    len = -1;
    if (n < 2) return;
    len = int'(f[1]) * 256 + int'(f[0]);
    if (len > (1 << ADDR_W)) return;
    need = 2 + 4 * len;
    for (int i = 0; i < len; i++) begin
      if (2 + 4 * i + 3 < n) begin
        w.adr = i[ADDR_W-1:0];
        w.dat = {f[2+4*i+3], f[2+4*i+2], f[2+4*i+1], f[2+4*i]};
        exp_q.push_back(w);
      end
    end
    if (n < need) return;
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    for (int k = 2; k < need; k++) sum = sum + f[k];
    if (n < need + 1) return;
    outcome = (f[need] == sum) ? 0 : 1;
`else
    outcome = 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_req);
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    load_req = with_req;
    tick();
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input int outcome);
    check({tag, "_done"}, upg_done_o, (outcome == 0));
    check({tag, "_hold"}, cpu_hold_o, (outcome != 0));
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_err"},  err_o, (outcome != 0));
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [7:0] f[$], input string tag, input bit inject);
    int outcome;
    int len;
    model(f, outcome, len);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check({tag, "_busy_start"}, {busy_o, cpu_hold_o, upg_done_o}, 3'b110);
    foreach (f[i])
      send_byte(f[i], $urandom_range(0, 3), inject && (i == 2) && (len >= 1));
    repeat (TIMEOUT_CYC + 10) tick();
    check_outcome(tag, outcome);
  endtask

  initial begin
    logic [7:0] f[$];
    int         bad;
    int         len;
    int         cut;

    repeat (3) tick();
    check("rst_outputs", {upg_done_o, cpu_hold_o, busy_o, err_o, upg_wen_o}, 5'b10000);
    check("rst_adr_dat", {upg_adr_o, upg_dat_o}, '0);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (upg_done_o !== 1'b1 || cpu_hold_o !== 1'b0 || upg_wen_o !== 1'b0) bad++;
    end
    check("idle_100_cycles", bad, 0);
    tick();

    f = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    f.push_back(8'h4C);
`endif
    run_frame(f, "two_words", 1'b0);

    f = '{8'h00, 8'h00};
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    f.push_back(8'h00);
`endif
    run_frame(f, "zero_len", 1'b0);

    f = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    run_frame(f, "timeout", 1'b0);
    check("timeout_model_err", err_o, 1'b1);

    f = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    f.push_back(8'hAA);
`endif
    run_frame(f, "reload_after_err", 1'b0);

    f = '{8'h01, 8'h40};
    run_frame(f, "len_too_big", 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(i * 37), 0, 1'b0);
    repeat (4) tick();
    check("err_ignores_rx", {err_o, cpu_hold_o, upg_done_o}, 3'b110);

`ifdef RISCV_IMEM_LOADER_CKSUM_EN
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_frame(f, "cksum_ok", 1'b0);
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    run_frame(f, "cksum_bad", 1'b0);
`else
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    run_frame(f, "trailer_ignored", 1'b0);
`endif

    // Reset mid-load returns to the bitstream-image-valid state immediately.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_load_reset", {upg_done_o, cpu_hold_o, busy_o, err_o}, 4'b1000);
    tick();
    rst = 1'b1;
    tick();

    for (int t = 0; t < 25; t++) begin
      f.delete();
      len = $urandom_range(0, 6);
      f.push_back(8'(len));
      f.push_back(8'h00);
      for (int k = 0; k < 4 * len; k++) f.push_back(8'($urandom));
`ifdef RISCV_IMEM_LOADER_CKSUM_EN
      begin
        logic [7:0] s;
        s = 8'h00;
        for (int k = 2; k < f.size(); k++) s = s + f[k];
        f.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : s);
      end
`endif
      if ($urandom_range(0, 4) == 0) begin
        cut = $urandom_range(1, f.size());
        while (f.size() > cut) void'(f.pop_back());
      end
      if ($urandom_range(0, 3) == 0) f.push_back(8'($urandom));
      run_frame(f, $sformatf("rand%0d", t), $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_imem_loader.md
Name: riscv_imem_loader

Overview:
- Sequences the UART-programmer write port of the instruction RAM.
- Consumes a byte stream from the UART receiver and frames it as length plus little-endian words.
- Drives upg_wen/upg_adr/upg_dat/upg_done into riscv_cache_i.
- Holds the CPU while a load is in progress, then releases memory ownership back to instruction fetch.

Parameters:
- ADDR_W, 14, word-address width of instruction RAM (max image = 2^ADDR_W words)
- TIMEOUT_CYC, 1000000, idle clk cycles between bytes before a load aborts
- TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- load_req  in  1  single-cycle pulse that starts a load; ignored while busy
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- upg_wen_o  out  1  one-cycle write strobe to instruction RAM
- upg_adr_o  out  ADDR_W  word address of the write
- upg_dat_o  out  32  write data
- upg_done_o  out  1  1 = image valid, fetch owns the RAM
- cpu_hold_o  out  1  1 = CPU held in reset
- busy_o  out  1  load in progress
- err_o  out  1  sticky error of the last load

Behaviour:
- Reset values: upg_done_o=1 (bitstream image valid), cpu_hold_o=0, busy_o=0, err_o=0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0; state IDLE; all counters 0.
- States: IDLE, LEN0, LEN1, DATA, DONE, ERR; CKSUM only with the optional feature.
- IDLE / DONE / ERR on load_req:
  - go to LEN0
  - upg_done_o<=0, cpu_hold_o<=1, busy_o<=1, err_o<=0
  - word index, byte index and timeout counter cleared
- LEN0: byte -> cnt[7:0]; go to LEN1.
- LEN1: byte -> cnt[15:8]; next state by the 16-bit count:
  - cnt==0 -> DONE (or CKSUM)
  - cnt>2^ADDR_W -> ERR
  - otherwise -> DATA
- DATA: bytes are little-endian; byte index 0..3 fills word[7:0] .. word[31:24].
- On the 4th byte:
  - next cycle upg_wen_o=1 for exactly 1 cycle, upg_adr_o=word index, upg_dat_o=assembled word
  - word index increments; byte index wraps to 0
  - after writing word cnt-1 -> DONE (or CKSUM)
- Write latency: upg_wen_o is registered and asserts 1 cycle after the rx_valid of the final byte. upg_adr_o/upg_dat_o hold until the next write.
- DONE: upg_done_o=1, cpu_hold_o=0, busy_o=0. The memory mux returns to fetch in the same cycle as cpu_hold_o drops.
- ERR: upg_done_o=0, cpu_hold_o=1 (a partial image never runs), busy_o=0, err_o=1. Only load_req or reset leaves ERR.
- Timeout:
  - in LEN0/LEN1/DATA/CKSUM the counter increments each cycle without rx_valid and clears on rx_valid
  - reaching TIMEOUT_CYC -> ERR; no write is issued for the partial word
- rx_valid in IDLE/DONE/ERR: ignored.
- load_req and rx_valid in the same cycle while busy: the byte is consumed normally and load_req is ignored.
- Word index at 2^ADDR_W-1 is the last legal address; it cannot wrap because cnt is bounded.
- Reset mid-load: immediate return to reset values, so upg_done_o=1 even though the RAM is partly overwritten. The software protocol requires a re-load after an aborted load.

Optional Feature:
- Macro: RISCV_IMEM_LOADER_CKSUM_EN.
- With the macro:
  - an 8-bit running sum (mod 256) covers every DATA byte
  - after the last word, state CKSUM waits for one trailer byte
  - trailer == sum -> DONE; trailer != sum -> ERR
  - the timeout also applies in CKSUM
- Without the macro: no CKSUM state and no sum register; the last word goes straight to DONE, and any trailer byte is ignored in DONE.

Decomposition:
- Package riscv_loader_pkg:
  - state enum (IDLE, LEN0, LEN1, DATA, CKSUM, DONE, ERR)
  - LEN_BYTES=2, WORD_BYTES=4
- Sub-module riscv_loader_timeout:
  - TO_W-bit counter
  - inputs: enable, clear
  - output: one-cycle expire pulse
  - reused later for the data-memory loader

Test Plan:
- Reset release, no stimulus -> upg_done_o=1, cpu_hold_o=0, upg_wen_o=0 for 100 cycles.
- load_req, bytes 02 00 78 56 34 12 EF BE AD DE -> writes adr 0 = 0x12345678 and adr 1 = 0xDEADBEEF, each wen 1 cycle. Then DONE: upg_done_o=1, cpu_hold_o=0, err_o=0.
- load_req, length 00 00 -> DONE with no write strobe. With CKSUM_EN, trailer 00 is needed first.
- load_req, length 01 00, then 2 data bytes and silence for TIMEOUT_CYC (set to 50) -> ERR: err_o=1, cpu_hold_o=1, upg_done_o=0, no write. A second load_req with a valid frame -> DONE, err_o=0.
- Length 01 40 (0x4001 > 16384) -> ERR immediately after LEN1, no writes.
- CKSUM_EN, frame 01 00 01 02 03 04:
  - trailer 0A -> DONE
  - trailer 0B -> ERR, with adr 0 = 0x04030201 already written
